// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock: 1 s prescaler, per-side mm:ss countdown with Fischer
// increment, pause, sticky flags and BCD time outputs.
//
// state     | meaning
// S_IDLE    | times loaded, waiting for start
// S_RUN     | prescaler running, side to move counts down
// S_PAUSED  | prescaler and times held
// S_FLAGGED | a side reached 00:00, everything frozen until load/reset
module chess_clock_ctrl #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int INIT_MIN    = 5,
  parameter int INIT_SEC    = 0,
  parameter int INC_SEC     = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             press,
  input  logic             pause_tgl,
  input  logic             load,
  output logic             turn,
  output logic             running,
  output logic             flag_white,
  output logic             flag_black,
  output logic             sec_tick,
  output logic [3:0][3:0]  time_white,
  output logic [3:0][3:0]  time_black
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_FLAGGED} state_t;

  localparam int            PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_CYCLES - 1);
  localparam logic [6:0]    INIT_M   = 7'(INIT_MIN);
  localparam logic [5:0]    INIT_S   = 6'(INIT_SEC);
  localparam logic [6:0]    INC_S    = 7'(INC_SEC);

  if (INIT_MIN == 0 && INIT_SEC == 0) begin : g_bad_init
    $error("chess_clock_ctrl: initial time 00:00 is not a playable game");
  end

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic          turn_q, running_q, flag_w_q, flag_b_q, tick_q;
  logic [6:0]    wmin_q, bmin_q;
  logic [5:0]    wsec_q, bsec_q;

  logic [6:0] mv_min, dec_min, base_min, inc_min, nxt_min_d;
  logic [5:0] mv_sec, dec_sec, base_sec, inc_sec, nxt_sec_d;
  logic [6:0] sec_sum;
  logic       tc, dec_zero;

  // Mover's next time: decrement on terminal count, then increment on press
  // unless that decrement just flagged the side.
  always_comb begin
    mv_min = turn_q ? bmin_q : wmin_q;
    mv_sec = turn_q ? bsec_q : wsec_q;
    tc     = (presc_q == PRESC_TC);

    if (mv_sec == 6'd0) begin
      dec_min = mv_min - 7'd1;
      dec_sec = 6'd59;
    end else begin
      dec_min = mv_min;
      dec_sec = mv_sec - 6'd1;
    end
    dec_zero = (dec_min == 7'd0) && (dec_sec == 6'd0);

    base_min = tc ? dec_min : mv_min;
    base_sec = tc ? dec_sec : mv_sec;

    sec_sum = {1'b0, base_sec} + INC_S;
    if (sec_sum >= 7'd60) begin
      inc_min = base_min + 7'd1;
      inc_sec = 6'(sec_sum - 7'd60);
    end else begin
      inc_min = base_min;
      inc_sec = sec_sum[5:0];
    end
    if (inc_min > 7'd99) begin
      inc_min = 7'd99;
      inc_sec = 6'd59;
    end

    if (press && !(tc && dec_zero)) begin
      nxt_min_d = inc_min;
      nxt_sec_d = inc_sec;
    end else begin
      nxt_min_d = base_min;
      nxt_sec_d = base_sec;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      turn_q    <= 1'b0;
      running_q <= 1'b0;
      flag_w_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      tick_q    <= 1'b0;
      wmin_q    <= INIT_M;
      wsec_q    <= INIT_S;
      bmin_q    <= INIT_M;
      bsec_q    <= INIT_S;
    end else begin
      tick_q <= 1'b0;
      if (load) begin
        state_q   <= S_IDLE;
        presc_q   <= '0;
        turn_q    <= 1'b0;
        running_q <= 1'b0;
        flag_w_q  <= 1'b0;
        flag_b_q  <= 1'b0;
        wmin_q    <= INIT_M;
        wsec_q    <= INIT_S;
        bmin_q    <= INIT_M;
        bsec_q    <= INIT_S;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
              turn_q    <= 1'b0;
              presc_q   <= '0;
            end
          end
          S_RUN: begin
            if (pause_tgl) begin
              state_q   <= S_PAUSED;
              running_q <= 1'b0;
            end else begin
              if (turn_q) begin
                bmin_q <= nxt_min_d;
                bsec_q <= nxt_sec_d;
              end else begin
                wmin_q <= nxt_min_d;
                wsec_q <= nxt_sec_d;
              end
              tick_q <= tc;
              if (tc && dec_zero) begin
                state_q   <= S_FLAGGED;
                running_q <= 1'b0;
                if (turn_q) flag_b_q <= 1'b1;
                else        flag_w_q <= 1'b1;
              end else if (press) begin
                turn_q  <= ~turn_q;
                presc_q <= '0;
              end else if (tc) begin
                presc_q <= '0;
              end else begin
                presc_q <= presc_q + PW'(1);
              end
            end
          end
          S_PAUSED: begin
            if (pause_tgl) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          S_FLAGGED: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign turn       = turn_q;
  assign running    = running_q;
  assign flag_white = flag_w_q;
  assign flag_black = flag_b_q;
  assign sec_tick   = tick_q;
  assign time_white = {to_bcd(wmin_q), to_bcd({1'b0, wsec_q})};
  assign time_black = {to_bcd(bmin_q), to_bcd({1'b0, bsec_q})};

endmodule
